// File: rtl/regfile_clear_engine.sv
// Register-file clear engine: zeroes r[START_REG..NUM_REGS-1], optionally reads each back.
// Optional read-back verify pass is compiled in with `define REGFILE_CLEAR_VERIFY_EN.
module regfile_clear_engine #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int START_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              stall_req,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
`ifdef REGFILE_CLEAR_VERIFY_EN
  localparam logic [1:0] S_VERIFY = 2'd2;
`endif
  localparam logic [1:0] S_DONE  = 2'd3;

  // Terminal compare is against the last real register, so ptr never wraps.
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(START_REG);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_CLEAR;
          ptr   <= FIRST;
        end
        S_CLEAR: begin
          if (ptr == LAST) begin
`ifdef REGFILE_CLEAR_VERIFY_EN
            state <= S_VERIFY;
            ptr   <= FIRST;
`else
            state <= S_DONE;
`endif
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
`ifdef REGFILE_CLEAR_VERIFY_EN
        S_VERIFY: begin
          if (ptr == LAST) state <= S_DONE;
          else             ptr   <= ptr + ADDR_W'(1);
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef REGFILE_CLEAR_VERIFY_EN
  logic              err_q;
  logic [ADDR_W-1:0] err_addr_q;

  // Only the first failing register is recorded; later failures leave err_addr alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (state == S_IDLE && start) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (state == S_VERIFY && (|rdata) && !err_q) begin
      err_q      <= 1'b1;
      err_addr_q <= ptr;
    end
  end

  assign busy     = (state == S_CLEAR) || (state == S_VERIFY);
  assign raddr    = (state == S_VERIFY) ? ptr : '0;
  assign error    = err_q;
  assign err_addr = err_addr_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^rdata;

  assign busy     = (state == S_CLEAR);
  assign raddr    = '0;
  assign error    = 1'b0;
  assign err_addr = '0;
`endif

  assign stall_req = busy;
  assign done      = (state == S_DONE);
  assign we        = (state == S_CLEAR);
  assign waddr     = we ? ptr : '0;
  assign wdata     = '0;

endmodule
